// File: rtl/uart_seq_ctrl_if.sv
// Bundles the requester-side and UART-side handshake signals of uart_seq_ctrl.
// master: the sequencing controller; slave: requesters plus UART model.
interface uart_seq_ctrl_if;
    logic       req0;
    logic       req1;
    logic [7:0] data0;
    logic [7:0] data1;
    logic       ack0;
    logic       ack1;
    logic [8:0] rdata;
    logic [3:0] err;
    logic       busy;
    logic       gnt;

    logic       u_write;
    logic       u_new_tx;
    logic       u_start_tx;
    logic       u_new_rx;
    logic       u_receive;
    logic [7:0] u_data;
    logic       u_pready_w;
    logic       u_pready_r;
    logic       u_rx_ready;
    logic       u_oe;
    logic       u_be;
    logic       u_fe;
    logic [8:0] u_data_out;

    modport master (
        input  req0, req1, data0, data1,
        input  u_pready_w, u_pready_r, u_rx_ready, u_oe, u_be, u_fe, u_data_out,
        output ack0, ack1, rdata, err, busy, gnt,
        output u_write, u_new_tx, u_start_tx, u_new_rx, u_receive, u_data
    );

    modport slave (
        output req0, req1, data0, data1,
        output u_pready_w, u_pready_r, u_rx_ready, u_oe, u_be, u_fe, u_data_out,
        input  ack0, ack1, rdata, err, busy, gnt,
        input  u_write, u_new_tx, u_start_tx, u_new_rx, u_receive, u_data
    );
endinterface

// File: rtl/uart_seq_ctrl.sv
// Round-robin two-requester UART transfer sequencer (IDLE/LOAD/START/RECV/DONE).
// Define UART_SEQ_TIMEOUT_EN to bound each handshake wait to Timeout cycles.
module uart_seq_ctrl #(
    parameter int unsigned Timeout = 4096
) (
    input logic             sys_clk_i,
    input logic             rst_ni,
    uart_seq_ctrl_if.master bus_io
);

    if (Timeout < 2 || Timeout > 65535) begin : g_bad_timeout
        $error("uart_seq_ctrl: Timeout must lie in 2..65535");
    end

    typedef enum logic [2:0] {StIdle, StLoad, StStart, StRecv, StDone} state_e;

    state_e     state_q;
    logic       rr_q;  // last requester served; resets to 1 so requester 0 wins first contention
    logic       gnt_q;
    logic       ack0_q, ack1_q, busy_q;
    logic       write_q, new_tx_q, start_tx_q, new_rx_q, receive_q;
    logic [7:0] u_data_q;
    logic [8:0] rdata_q;
    logic [3:0] err_q;
    logic       pick;

    always_comb begin
        if (bus_io.req0 && bus_io.req1) pick = ~rr_q;
        else                            pick = bus_io.req1;
    end

`ifdef UART_SEQ_TIMEOUT_EN
    logic [15:0] cnt_q;
    logic        hs;
    logic        tmo;

    // Non-wait states count as "handshake present" so the counter stays cleared there.
    always_comb begin
        hs = 1'b1;
        unique case (state_q)
            StLoad:  hs = bus_io.u_pready_w;
            StStart: hs = bus_io.u_rx_ready;
            StRecv:  hs = bus_io.u_pready_r;
            default: hs = 1'b1;
        endcase
    end

    assign tmo = !hs && (cnt_q == 16'(Timeout - 1));

    always_ff @(posedge sys_clk_i or negedge rst_ni) begin
        if (!rst_ni)        cnt_q <= '0;
        else if (hs || tmo) cnt_q <= '0;
        else                cnt_q <= cnt_q + 16'd1;
    end
`endif

    always_ff @(posedge sys_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            rr_q       <= 1'b1;
            gnt_q      <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            busy_q     <= 1'b0;
            write_q    <= 1'b0;
            new_tx_q   <= 1'b0;
            start_tx_q <= 1'b0;
            new_rx_q   <= 1'b0;
            receive_q  <= 1'b0;
            u_data_q   <= '0;
            rdata_q    <= '0;
            err_q      <= '0;
        end else begin
            new_tx_q <= 1'b0;
            new_rx_q <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
`ifdef UART_SEQ_TIMEOUT_EN
            if (tmo) begin
                state_q    <= StDone;
                write_q    <= 1'b0;
                start_tx_q <= 1'b0;
                receive_q  <= 1'b0;
                rdata_q    <= '0;
                err_q      <= 4'b1000;
                ack0_q     <= ~gnt_q;
                ack1_q     <= gnt_q;
            end else
`endif
            begin
                unique case (state_q)
                    StIdle: begin
                        if (bus_io.req0 || bus_io.req1) begin
                            gnt_q    <= pick;
                            rr_q     <= pick;
                            u_data_q <= pick ? bus_io.data1 : bus_io.data0;
                            busy_q   <= 1'b1;
                            write_q  <= 1'b1;
                            new_tx_q <= 1'b1;
                            state_q  <= StLoad;
                        end
                    end
                    StLoad: begin
                        if (bus_io.u_pready_w) begin
                            write_q    <= 1'b0;
                            start_tx_q <= 1'b1;
                            state_q    <= StStart;
                        end
                    end
                    StStart: begin
                        if (bus_io.u_rx_ready) begin
                            start_tx_q <= 1'b0;
                            new_rx_q   <= 1'b1;
                            receive_q  <= 1'b1;
                            state_q    <= StRecv;
                        end
                    end
                    StRecv: begin
                        if (bus_io.u_pready_r) begin
                            receive_q <= 1'b0;
                            rdata_q   <= bus_io.u_data_out;
                            err_q     <= {1'b0, bus_io.u_oe, bus_io.u_be, bus_io.u_fe};
                            ack0_q    <= ~gnt_q;
                            ack1_q    <= gnt_q;
                            state_q   <= StDone;
                        end
                    end
                    StDone: begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign bus_io.ack0       = ack0_q;
    assign bus_io.ack1       = ack1_q;
    assign bus_io.rdata      = rdata_q;
    assign bus_io.err        = err_q;
    assign bus_io.busy       = busy_q;
    assign bus_io.gnt        = gnt_q;
    assign bus_io.u_write    = write_q;
    assign bus_io.u_new_tx   = new_tx_q;
    assign bus_io.u_start_tx = start_tx_q;
    assign bus_io.u_new_rx   = new_rx_q;
    assign bus_io.u_receive  = receive_q;
    assign bus_io.u_data     = u_data_q;

endmodule

// File: tb/tb_uart_seq_ctrl.sv
// Directed bench for uart_seq_ctrl: loopback UART model, scoreboard of expected acks.
// Covers the UART_SEQ_TIMEOUT_EN build and the default build.
module tb_uart_seq_ctrl;
    localparam int unsigned Timeout = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    typedef struct packed {
        logic       idx;
        logic [8:0] rdata;
        logic [3:0] err;
    } exp_t;

    exp_t sb_q[$];

    uart_seq_ctrl_if ifc ();

    uart_seq_ctrl #(.Timeout(Timeout)) dut (
        .sys_clk_i (clk),
        .rst_ni    (rst_n),
        .bus_io    (ifc)
    );

    always #5 clk = ~clk;

    // UART loopback: the received word echoes the transmitted byte.
    assign ifc.u_data_out = {1'b0, ifc.u_data};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [29:0] outs();
        return {ifc.ack0, ifc.ack1, ifc.rdata, ifc.err, ifc.busy, ifc.gnt, ifc.u_write,
                ifc.u_new_tx, ifc.u_start_tx, ifc.u_new_rx, ifc.u_receive, ifc.u_data};
    endfunction

    // {u_new_tx, u_write, u_start_tx, u_new_rx, u_receive}
    function automatic logic [4:0] ctrl();
        return {ifc.u_new_tx, ifc.u_write, ifc.u_start_tx, ifc.u_new_rx, ifc.u_receive};
    endfunction

    task automatic wait_ack(input int budget, input string tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(ifc.ack0 || ifc.ack1) && n < budget);
        chk(tag, 32'(ifc.ack0 || ifc.ack1), 32'd1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (ifc.ack0 || ifc.ack1)) begin
            chk("ack_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("ack_result", {ifc.ack1, ifc.ack0, ifc.gnt, ifc.rdata, ifc.err},
                    {e.idx, ~e.idx, e.idx, e.rdata, e.err});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  n_rx;
        bit  seen;
        ifc.req0 = 0; ifc.req1 = 0; ifc.data0 = '0; ifc.data1 = '0;
        ifc.u_pready_w = 0; ifc.u_pready_r = 0; ifc.u_rx_ready = 0;
        ifc.u_oe = 0; ifc.u_be = 0; ifc.u_fe = 0;

        // Reset state
        step(); step();
        chk("reset_outputs", 32'(outs()), 32'd0);
        rst_n = 1'b1;

        // Single transfer, all handshakes already high: cycle-exact sequencing
        ifc.u_pready_w = 1; ifc.u_rx_ready = 1; ifc.u_pready_r = 1;
        ifc.req0 = 1; ifc.data0 = 8'hA5;
        sb_q.push_back('{idx: 1'b0, rdata: 9'h0A5, err: 4'h0});
        step();
        ifc.req0 = 0;  // dropped mid-transfer: ack must still arrive
        chk("b_load_ctrl", 32'(ctrl()), 32'b11000);
        chk("b_load_busy_gnt", 32'({ifc.busy, ifc.gnt}), 32'b10);
        chk("b_u_data", 32'(ifc.u_data), 32'hA5);
        step();
        chk("b_start_ctrl", 32'(ctrl()), 32'b00100);
        step();
        chk("b_recv_ctrl", 32'(ctrl()), 32'b00011);
        step();
        chk("b_done_ack0", 32'({ifc.ack0, ifc.ack1}), 32'b10);
        chk("b_done_ctrl", 32'(ctrl()), 32'b00000);
        step();
        chk("b_idle", 32'({ifc.busy, ifc.ack0, ctrl()}), 32'd0);

        // Error flags captured and held
        ifc.u_oe = 1; ifc.u_fe = 1;
        ifc.req1 = 1; ifc.data1 = 8'h3C;
        sb_q.push_back('{idx: 1'b1, rdata: 9'h03C, err: 4'b0101});
        step();
        ifc.req1 = 0;
        wait_ack(10, "c_ack");
        ifc.u_oe = 0; ifc.u_fe = 0;
        repeat (3) step();
        chk("c_err_held", 32'({ifc.rdata, ifc.err}), 32'({9'h03C, 4'b0101}));

        // Reset during START: immediate clear, no ack
        ifc.u_rx_ready = 0;
        ifc.req0 = 1; ifc.data0 = 8'h77;
        step();
        ifc.req0 = 0;
        step(); step();
        chk("d_in_start", 32'({ifc.busy, ctrl()}), 32'b100100);
        #2 rst_n = 1'b0;
        #1 chk("d_async_clear", 32'(outs()), 32'd0);
        step();
        rst_n = 1'b1;
        ifc.u_rx_ready = 1;

        // Round-robin contention from reset: grants 0,1,0
        ifc.req0 = 1; ifc.req1 = 1; ifc.data0 = 8'h11; ifc.data1 = 8'h22;
        sb_q.push_back('{idx: 1'b0, rdata: 9'h011, err: 4'h0});
        sb_q.push_back('{idx: 1'b1, rdata: 9'h022, err: 4'h0});
        sb_q.push_back('{idx: 1'b0, rdata: 9'h011, err: 4'h0});
        for (int i = 0; i < 3; i++) begin
            wait_ack(10, "e_ack");
            if (i == 2) begin
                ifc.req0 = 0; ifc.req1 = 0;
            end
            step();
            chk("e_idle_gap", 32'(ifc.busy), 32'd0);
        end

        // Receive handshake withheld
        ifc.u_pready_r = 0;
        ifc.req0 = 1; ifc.data0 = 8'h5A;
`ifdef UART_SEQ_TIMEOUT_EN
        sb_q.push_back('{idx: 1'b0, rdata: 9'h000, err: 4'b1000});
        n_rx = 0;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (i == 0) ifc.req0 = 0;
            if (ifc.u_receive) n_rx++;
            if (ifc.ack0 || ifc.ack1) begin
                seen = 1;
                chk("f_receive_low_done", 32'(ifc.u_receive), 32'd0);
            end
        end
        chk("f_timeout_ack", 32'(seen), 32'd1);
        chk("f_recv_cycles", 32'(n_rx), 32'd16);
        ifc.u_pready_r = 1;
        step();
`else
        step();
        ifc.req0 = 0;
        seen = 0;
        n_rx = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (ifc.ack0 || ifc.ack1) seen = 1;
            if (ifc.u_receive) n_rx++;
        end
        chk("f_unbounded_no_ack", 32'(seen), 32'd0);
        chk("f_still_receiving", 32'({ifc.busy, ifc.u_receive, n_rx[7:0]}), 32'({2'b11, 8'd39}));
        sb_q.push_back('{idx: 1'b0, rdata: 9'h05A, err: 4'h0});
        ifc.u_pready_r = 1;
        wait_ack(5, "f_ack");
        step();
`endif
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_seq_ctrl.md
UART_SEQ_CTRL -- requirements
Module: uart_seq_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 4096: maximum cycles any handshake wait state may last; legal range 2..65535.
REQ-002 SysClk  input  1  system clock; all logic is on the rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 req0 / req1  input  1 each  transfer request from requester 0 / requester 1.
REQ-005 data0 / data1  input  8 each  byte to send for requester 0 / requester 1.
REQ-006 ack0 / ack1  output  1 each  one-cycle completion strobe to requester 0 / requester 1.
REQ-007 rdata  output  9  received word, captured from u_data_out.
REQ-008 err  output  4  {timeout, OE, BE, FE} for the completed transfer.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 gnt  output  1  index of the requester currently or last served.
REQ-011 u_write, u_new_tx, u_start_tx, u_new_rx, u_receive  output  1 each  UART sequencing controls.
REQ-012 u_data  output  8  byte presented to the UART Tx path.
REQ-013 u_pready_w, u_pready_r, u_rx_ready  input  1 each  UART handshake returns.
REQ-014 u_oe, u_be, u_fe  input  1 each  UART error flags.
REQ-015 u_data_out  input  9  UART received word.

Function
REQ-016 The FSM SHALL have exactly five states: IDLE, LOAD, START, RECV, DONE.
REQ-017 IDLE: the block SHALL grant when any req is high.
- Only one req high: grant that requester.
- Both high: grant the requester other than the last one served (round-robin).
- On grant: latch the granted data into u_data, update gnt, go to LOAD next cycle.
REQ-018 LOAD behaviour:
- u_new_tx SHALL pulse high on the first LOAD cycle only.
- u_write SHALL stay high every LOAD cycle.
- On u_pready_w=1 go to START.
REQ-019 START: u_start_tx SHALL stay high until u_rx_ready=1, then go to RECV.
REQ-020 RECV behaviour:
- u_new_rx SHALL pulse high on the first RECV cycle only.
- u_receive SHALL stay high every RECV cycle.
- On u_pready_r=1, capture u_data_out into rdata and {u_oe,u_be,u_fe} into err[2:0], then go to DONE.
REQ-021 DONE: the block SHALL assert ack of the granted requester for exactly one cycle, then return to IDLE.
REQ-022 In DONE, rdata and err SHALL hold until the next DONE.
REQ-023 All u_* control outputs SHALL be low in IDLE and DONE.
REQ-024 Handshake inputs SHALL be ignored outside the state that waits on them.
REQ-025 Minimum latency: with all handshakes already high, ack SHALL rise 4 cycles after the IDLE grant cycle.
REQ-026 Dropping req mid-transfer SHALL NOT abort the transfer; the ack is still issued.
REQ-027 A req high during DONE SHALL be arbitrated in the following IDLE cycle; at least one IDLE cycle occurs between transfers.
REQ-028 Each grant SHALL update the round-robin pointer, including grants to a sole requester.

Reset
REQ-029 On rst=0 the block SHALL, asynchronously:
- force state to IDLE;
- drive all outputs to 0;
- set the round-robin pointer so requester 0 wins the first contention.
REQ-030 Reset asserted mid-transfer SHALL abort the transfer with no ack and no rdata update.

Configuration
REQ-031 Macro UART_SEQ_TIMEOUT_EN:
- Defined: a cycle counter runs in LOAD, START and RECV and clears on every state change. Reaching TIMEOUT cycles in one state without its handshake SHALL force DONE with err=4'b1000, rdata=0, and ack still issued.
- Undefined: no counter exists, waits are unbounded, and err[3] SHALL be constant 0.

Verification
REQ-032 req0=1, data0=8'hA5, UART echoes immediately with u_data_out=9'h0A5 -> u_new_tx pulse, u_write, u_start_tx, u_new_rx pulse, u_receive in order; ack0 4 cycles after grant; rdata=9'h0A5; err=0.
REQ-033 req0 and req1 high together for 3 transfers -> grants 0,1,0; each ack belongs to the matching requester.
REQ-034 u_pready_r held 0, macro defined, TIMEOUT=16 -> DONE after 16 RECV cycles; err=4'b1000; ack issued; u_receive low in DONE.
REQ-035 rst pulsed low during START -> all outputs 0 immediately; no ack; next transfer starts cleanly from IDLE.
REQ-036 u_fe=1 and u_oe=1 at u_pready_r -> err=4'b0101 held until the next transfer completes.
